// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_BURST = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step_comb.sv
// One shift step: next register value and shifted-out bits for a given op.
// HOLD, LOAD and BURST leave q untouched here; the top decides those.
module shift_step_comb
  import shift_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic [N-1:0] q_i,
  input  logic [S-1:0] sin_i,
  input  logic [2:0]   op_i,
  output logic [N-1:0] q_o,
  output logic [S-1:0] sout_o,
  output logic         sout_upd_o
);

  always_comb begin
    q_o        = q_i;
    sout_o     = '0;
    sout_upd_o = 1'b0;
    case (op_i)
      MODE_SHL: begin
        q_o        = {q_i[N-S-1:0], sin_i};
        sout_o     = q_i[N-1:N-S];
        sout_upd_o = 1'b1;
      end
      MODE_SHR: begin
        q_o        = {sin_i, q_i[N-1:S]};
        sout_o     = q_i[S-1:0];
        sout_upd_o = 1'b1;
      end
      MODE_ROL: begin
        q_o        = {q_i[N-S-1:0], q_i[N-1:N-S]};
        sout_o     = q_i[N-1:N-S];
        sout_upd_o = 1'b1;
      end
      MODE_ROR: begin
        q_o        = {q_i[S-1:0], q_i[N-1:S]};
        sout_o     = q_i[S-1:0];
        sout_upd_o = 1'b1;
      end
      MODE_ASR: begin
        q_o        = {{S{q_i[N-1]}}, q_i[N-1:S]};
        sout_o     = q_i[S-1:0];
        sout_upd_o = 1'b1;
      end
      default: begin
        q_o        = q_i;
        sout_o     = '0;
        sout_upd_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/u_shift_reg_burst.sv
// Universal shift register with single-step ops and an autonomous burst serializer.
// Handshake: busy is high for every cycle a burst is shifting; done pulses for one cycle after the last step.
module u_shift_reg_burst
  import shift_pkg::*;
#(
  parameter int N     = 8,
  parameter int S     = 1,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             dir,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     d,
  input  logic [S-1:0]     sin,
  output logic [N-1:0]     q,
  output logic [S-1:0]     sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic [S-1:0]     sout_q, sout_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic [2:0]       step_op;
  logic [N-1:0]     step_q;
  logic [S-1:0]     step_sout;
  logic             step_upd;

  shift_step_comb #(.N(N), .S(S)) u_step (
    .q_i        (q_q),
    .sin_i      (sin),
    .op_i       (step_op),
    .q_o        (step_q),
    .sout_o     (step_sout),
    .sout_upd_o (step_upd)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_op = mode;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (mode == MODE_BURST) begin
            // Start edge only latches the job; shifting begins on the next edge.
            dir_d   = dir;
            cnt_d   = len;
            state_d = (len == '0) ? ST_DONE : ST_RUN;
          end else if (mode == MODE_LOAD) begin
            q_d = d;
          end else begin
            q_d = step_q;
            if (step_upd) sout_d = step_sout;
          end
        end
      end
      ST_RUN: begin
        step_op = dir_q ? MODE_SHR : MODE_SHL;
        q_d     = step_q;
        sout_d  = step_sout;
        if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q <= LEN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      sout_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_u_shift_reg_burst.sv
// Directed bench for u_shift_reg_burst: an S=1 and an S=2 instance share controls, each with its own enable.
module tb_u_shift_reg_burst;
  import shift_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en1, en2;
  logic [2:0] mode;
  logic       dir;
  logic [3:0] len;
  logic [7:0] d;
  logic [0:0] sin1;
  logic [1:0] sin2;
  logic [7:0] q1, q2;
  logic [0:0] sout1;
  logic [1:0] sout2;
  logic       busy1, busy2, done1, done2;

  u_shift_reg_burst #(.N(8), .S(1), .LEN_W(4)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .mode(mode), .dir(dir), .len(len),
    .d(d), .sin(sin1), .q(q1), .sout(sout1), .busy(busy1), .done(done1)
  );

  u_shift_reg_burst #(.N(8), .S(2), .LEN_W(4)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .mode(mode), .dir(dir), .len(len),
    .d(d), .sin(sin2), .q(q2), .sout(sout2), .busy(busy2), .done(done2)
  );

  // scoreboard: {q, sout} expectations
  logic [15:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] m_q1, m_s1, m_q2, m_s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference step model built from arithmetic shifts on the byte value.
  function automatic logic [15:0] model(input logic [2:0] op, input logic [7:0] qv,
                                        input logic [7:0] sv, input logic [7:0] cur_s,
                                        input logic [7:0] ld, input int s);
    logic [7:0] qn, so, mask;
    mask = 8'((1 << s) - 1);
    qn = qv;
    so = cur_s;
    case (op)
      MODE_SHL: begin qn = 8'(qv << s) | (sv & mask);  so = qv >> (8 - s); end
      MODE_SHR: begin qn = (qv >> s) | 8'(sv << (8 - s)); so = qv & mask; end
      MODE_ROL: begin qn = 8'(qv << s) | (qv >> (8 - s)); so = qv >> (8 - s); end
      MODE_ROR: begin qn = (qv >> s) | 8'(qv << (8 - s)); so = qv & mask; end
      MODE_ASR: begin qn = 8'($signed(qv) >>> s); so = qv & mask; end
      MODE_LOAD: qn = ld;
      default: ;
    endcase
    return {qn, so};
  endfunction

  // driver tasks
  task automatic op1(input string tag, input logic [2:0] op, input logic [7:0] dv,
                     input logic sv, input logic env);
    logic [15:0] e;
    e = env ? model(op, m_q1, {7'b0, sv}, m_s1, dv, 1) : {m_q1, m_s1};
    exp_q.push_back(e);
    mode = op; d = dv; sin1 = sv; en1 = env;
    tick();
    en1 = 1'b0;
    e = exp_q.pop_front();
    m_q1 = e[15:8];
    m_s1 = e[7:0];
    check({tag, "_q"}, {24'b0, q1}, {24'b0, m_q1});
    check({tag, "_sout"}, {31'b0, sout1}, {24'b0, m_s1});
  endtask

  task automatic op2(input string tag, input logic [2:0] op, input logic [7:0] dv,
                     input logic [1:0] sv, input logic env);
    logic [15:0] e;
    e = env ? model(op, m_q2, {6'b0, sv}, m_s2, dv, 2) : {m_q2, m_s2};
    exp_q.push_back(e);
    mode = op; d = dv; sin2 = sv; en2 = env;
    tick();
    en2 = 1'b0;
    e = exp_q.pop_front();
    m_q2 = e[15:8];
    m_s2 = e[7:0];
    check({tag, "_q"}, {24'b0, q2}, {24'b0, m_q2});
    check({tag, "_sout"}, {30'b0, sout2}, {24'b0, m_s2});
  endtask

  task automatic burst1(input string tag, input logic dirv, input int lenv,
                        input logic sinv, input logic ld_during);
    logic [7:0]  tq, ts;
    logic [15:0] e;
    tq = m_q1;
    ts = m_s1;
    for (int k = 0; k < lenv; k++) begin
      e = model(dirv ? MODE_SHR : MODE_SHL, tq, {7'b0, sinv}, ts, 8'h00, 1);
      exp_q.push_back(e);
      tq = e[15:8];
      ts = e[7:0];
    end
    mode = MODE_BURST; dir = dirv; len = 4'(lenv); sin1 = sinv; en1 = 1'b1;
    tick();
    check({tag, "_start_q"}, {24'b0, q1}, {24'b0, m_q1});
    check({tag, "_start_busy"}, {31'b0, busy1}, (lenv == 0) ? 32'd0 : 32'd1);
    check({tag, "_start_done"}, {31'b0, done1}, (lenv == 0) ? 32'd1 : 32'd0);
    if (ld_during) begin
      mode = MODE_LOAD;
      d    = 8'hFF;
    end else begin
      en1 = 1'b0;
    end
    for (int k = 1; k <= lenv; k++) begin
      tick();
      e = exp_q.pop_front();
      m_q1 = e[15:8];
      m_s1 = e[7:0];
      check($sformatf("%s_step%0d_q", tag, k), {24'b0, q1}, {24'b0, m_q1});
      check($sformatf("%s_step%0d_sout", tag, k), {31'b0, sout1}, {24'b0, m_s1});
      check($sformatf("%s_step%0d_busy", tag, k), {31'b0, busy1}, (k < lenv) ? 32'd1 : 32'd0);
      check($sformatf("%s_step%0d_done", tag, k), {31'b0, done1}, (k == lenv) ? 32'd1 : 32'd0);
    end
    en1  = 1'b0;
    mode = MODE_HOLD;
    tick();
    check({tag, "_after_done"}, {31'b0, done1}, 32'd0);
    check({tag, "_after_busy"}, {31'b0, busy1}, 32'd0);
    check({tag, "_after_q"}, {24'b0, q1}, {24'b0, m_q1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    reset = 1'b0; en1 = 1'b0; en2 = 1'b0; mode = MODE_HOLD; dir = 1'b0;
    len = 4'd0; d = 8'h00; sin1 = 1'b0; sin2 = 2'b00;
    m_q1 = 8'h00; m_s1 = 8'h00; m_q2 = 8'h00; m_s2 = 8'h00;
    #3;
    check("por_q1", {24'b0, q1}, 32'd0);
    check("por_busy1", {31'b0, busy1}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    check("rst_q1", {24'b0, q1}, 32'd0);
    check("rst_sout1", {31'b0, sout1}, 32'd0);
    check("rst_done1", {31'b0, done1}, 32'd0);
    check("rst_q2", {24'b0, q2}, 32'd0);

    // S=1 single steps
    op1("ld_a5", MODE_LOAD, 8'hA5, 1'b0, 1'b1);
    op1("shl", MODE_SHL, 8'h00, 1'b1, 1'b1);
    op1("shr", MODE_SHR, 8'h00, 1'b0, 1'b1);
    op1("hold", MODE_HOLD, 8'h00, 1'b1, 1'b1);
    op1("en0_shl", MODE_SHL, 8'h00, 1'b1, 1'b0);
    op1("en0_ld", MODE_LOAD, 8'hFF, 1'b0, 1'b0);

    // S=2 single steps
    op2("s2_ld96", MODE_LOAD, 8'h96, 2'b00, 1'b1);
    op2("s2_rol", MODE_ROL, 8'h00, 2'b00, 1'b1);
    op2("s2_asr_pos", MODE_ASR, 8'h00, 2'b00, 1'b1);
    op2("s2_ld96b", MODE_LOAD, 8'h96, 2'b00, 1'b1);
    op2("s2_asr_neg", MODE_ASR, 8'h00, 2'b00, 1'b1);
    op2("s2_ror", MODE_ROR, 8'h00, 2'b00, 1'b1);
    op2("s2_shr", MODE_SHR, 8'h00, 2'b11, 1'b1);
    op2("s2_shl", MODE_SHL, 8'h00, 2'b10, 1'b1);
    op2("s2_en0", MODE_ROL, 8'h00, 2'b01, 1'b0);

    // Bursts
    op1("ld_c3", MODE_LOAD, 8'hC3, 1'b0, 1'b1);
    burst1("b8_left", 1'b0, 8, 1'b0, 1'b0);
    op1("ld_5a", MODE_LOAD, 8'h5A, 1'b0, 1'b1);
    burst1("b0", 1'b1, 0, 1'b1, 1'b0);
    burst1("b3_right_ld", 1'b1, 3, 1'b1, 1'b1);
    burst1("b15_right", 1'b1, 15, 1'b0, 1'b0);

    // Reset in the third busy cycle of a burst
    op1("ld_f0", MODE_LOAD, 8'hF0, 1'b0, 1'b1);
    mode = MODE_BURST; dir = 1'b0; len = 4'd5; sin1 = 1'b0; en1 = 1'b1;
    tick();
    en1 = 1'b0;
    tick();
    tick();
    e = model(MODE_SHL, m_q1, 8'h00, m_s1, 8'h00, 1);
    e = model(MODE_SHL, e[15:8], 8'h00, e[7:0], 8'h00, 1);
    check("abort_pre_q", {24'b0, q1}, {24'b0, e[15:8]});
    check("abort_pre_busy", {31'b0, busy1}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_q", {24'b0, q1}, 32'd0);
    check("abort_sout", {31'b0, sout1}, 32'd0);
    check("abort_busy", {31'b0, busy1}, 32'd0);
    check("abort_done", {31'b0, done1}, 32'd0);
    tick();
    check("abort_no_done", {31'b0, done1}, 32'd0);
    reset = 1'b1;
    m_q1 = 8'h00; m_s1 = 8'h00; m_q2 = 8'h00; m_s2 = 8'h00;
    op1("ld_81", MODE_LOAD, 8'h81, 1'b0, 1'b1);
    burst1("b2_after_rst", 1'b1, 2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
